fft8_input_reorder: RTL

FFT8_INPUT_REORDER -- requirements
Module: fft8_input_reorder

---
 rtl/fft8_input_reorder_pkg.sv | 43 ++++
 rtl/fft8_input_reorder.sv | 117 +++++++++++
 2 files changed

// File: rtl/fft8_input_reorder_pkg.sv
// Shared 8-point FFT constants: frame size, default word width, twiddles
// and the 3-bit bit-reversal used by the reorder stages.
package fft8_input_reorder_pkg;

    localparam int unsigned FFT_N          = 8;
    localparam int unsigned LOG2_N         = 3;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned TW_W           = 16;

    // Bit-reversed index within an 8-point frame.
    function automatic logic [LOG2_N-1:0] rev3(input logic [LOG2_N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

    // W8^k real part in Q1.15 for k = 0..3.
    function automatic logic signed [TW_W-1:0] twiddle_re(input logic [1:0] k);
        logic signed [TW_W-1:0] tw;
        tw = TW_W'(0);
        case (k)
            2'd0: tw = 16'sh7FFF;
            2'd1: tw = 16'sh5A82;
            2'd2: tw = 16'sh0000;
            2'd3: tw = 16'shA57E;
            default: tw = TW_W'(0);
        endcase
        return tw;
    endfunction

    // W8^k imaginary part in Q1.15 for k = 0..3.
    function automatic logic signed [TW_W-1:0] twiddle_im(input logic [1:0] k);
        logic signed [TW_W-1:0] tw;
        tw = TW_W'(0);
        case (k)
            2'd0: tw = 16'sh0000;
            2'd1: tw = 16'shA57E;
            2'd2: tw = 16'sh8000;
            2'd3: tw = 16'shA57E;
            default: tw = TW_W'(0);
        endcase
        return tw;
    endfunction

endpackage

// File: rtl/fft8_input_reorder.sv
// Collects 8 serial complex samples into bit-reversed slots and presents
// them as a registered parallel frame for the first butterfly stage.
module fft8_input_reorder
    import fft8_input_reorder_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic [DATA_W-1:0] x0_real,
    output logic [DATA_W-1:0] x1_real,
    output logic [DATA_W-1:0] x2_real,
    output logic [DATA_W-1:0] x3_real,
    output logic [DATA_W-1:0] x4_real,
    output logic [DATA_W-1:0] x5_real,
    output logic [DATA_W-1:0] x6_real,
    output logic [DATA_W-1:0] x7_real,
    output logic [DATA_W-1:0] x0_imag,
    output logic [DATA_W-1:0] x1_imag,
    output logic [DATA_W-1:0] x2_imag,
    output logic [DATA_W-1:0] x3_imag,
    output logic [DATA_W-1:0] x4_imag,
    output logic [DATA_W-1:0] x5_imag,
    output logic [DATA_W-1:0] x6_imag,
    output logic [DATA_W-1:0] x7_imag,
    output logic              out_valid,
    output logic              sop_err
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(FFT_N - 1);

    logic [LOG2_N-1:0] n;
    logic [DATA_W-1:0] slot_re [FFT_N];
    logic [DATA_W-1:0] slot_im [FFT_N];
    logic [DATA_W-1:0] xr      [FFT_N];
    logic [DATA_W-1:0] xi      [FFT_N];

    logic restart_c;
    logic frame_done_c;
    logic [LOG2_N-1:0] wr_slot_c;

    // Early in_sop restarts the frame; the last sample completes it.
    always_comb begin
        restart_c    = in_valid && in_sop && (n != '0);
        frame_done_c = in_valid && !restart_c && (n == LAST_IDX);
        wr_slot_c    = restart_c ? '0 : rev3(n);
    end

    // Sample index and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n         <= '0;
            out_valid <= 1'b0;
            sop_err   <= 1'b0;
        end else begin
            out_valid <= frame_done_c;
            sop_err   <= restart_c;
            if (restart_c) begin
                n <= LOG2_N'(1);
            end else if (in_valid) begin
                n <= n + LOG2_N'(1);
            end
        end
    end

    // Collection slots, written in bit-reversed order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FFT_N; k++) begin
                slot_re[k] <= '0;
                slot_im[k] <= '0;
            end
        end else if (in_valid) begin
            slot_re[wr_slot_c] <= in_real;
            slot_im[wr_slot_c] <= in_imag;
        end
    end

    // Output frame; the final sample bypasses its slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FFT_N; k++) begin
                xr[k] <= '0;
                xi[k] <= '0;
            end
        end else if (frame_done_c) begin
            for (int k = 0; k < FFT_N - 1; k++) begin
                xr[k] <= slot_re[k];
                xi[k] <= slot_im[k];
            end
            xr[FFT_N-1] <= in_real;
            xi[FFT_N-1] <= in_imag;
        end
    end

    assign x0_real = xr[0];
    assign x1_real = xr[1];
    assign x2_real = xr[2];
    assign x3_real = xr[3];
    assign x4_real = xr[4];
    assign x5_real = xr[5];
    assign x6_real = xr[6];
    assign x7_real = xr[7];
    assign x0_imag = xi[0];
    assign x1_imag = xi[1];
    assign x2_imag = xi[2];
    assign x3_imag = xi[3];
    assign x4_imag = xi[4];
    assign x5_imag = xi[5];
    assign x6_imag = xi[6];
    assign x7_imag = xi[7];

endmodule
